// File: rtl/channel_arb_pkg.sv
// Shared types and constants for the constant-add channel arbiter.
package channel_arb_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   localparam int unsigned NREQ_DEFAULT      = 4;
   localparam int unsigned ADD_CONST_DEFAULT = 2;

   // Requester-id tag width; a single requester still needs one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned ID_W_DEFAULT = id_width(NREQ_DEFAULT);

endpackage

// File: rtl/channel_add_pipe.sv
// LATENCY-stage valid/tag/data shift pipe that adds ADD_CONST on entry.
module channel_add_pipe #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned ID_W      = 2,
   parameter int unsigned LATENCY   = 2,
   parameter int unsigned ADD_CONST = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [ID_W-1:0]  in_tag,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [ID_W-1:0]  out_tag,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   logic [LATENCY-1:0] valid_q;
   logic [ID_W-1:0]    tag_q  [LATENCY];
   logic [WIDTH-1:0]   data_q [LATENCY];

   // Payload registers only move with a valid, so the last stage holds its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int unsigned s = 0; s < LATENCY; s++) begin
            tag_q[s]  <= '0;
            data_q[s] <= '0;
         end
      end else begin
         valid_q[0] <= in_valid;
         if (in_valid) begin
            tag_q[0]  <= in_tag;
            data_q[0] <= in_data + WIDTH'(ADD_CONST);
         end
         for (int unsigned s = 1; s < LATENCY; s++) begin
            valid_q[s] <= valid_q[s-1];
            if (valid_q[s-1]) begin
               tag_q[s]  <= tag_q[s-1];
               data_q[s] <= data_q[s-1];
            end
         end
      end
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_tag   = tag_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];
   assign busy      = |valid_q;

endmodule

// File: rtl/channel_add_arbiter.sv
// Round-robin arbiter sharing one pipelined constant-add channel among NREQ requesters,
// with flush/drain sequencing. Optional CHANNEL_ARB_STATS_EN adds per-requester grant counters.
module channel_add_arbiter
   import channel_arb_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned NREQ      = NREQ_DEFAULT,
   parameter int unsigned LATENCY   = 2,
   parameter int unsigned ADD_CONST = ADD_CONST_DEFAULT,
   parameter int unsigned MAX_OUT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]      resp_data,
   input  logic                  flush,
   output logic                  flush_done,
   output logic                  busy
`ifdef CHANNEL_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0]    grant_count
`endif
);

   localparam int unsigned ID_W  = id_width(NREQ);
   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

   arb_state_t       state, state_nxt;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_any;
   logic [CNT_W-1:0] outstanding [NREQ];
   logic             pipe_valid;
   logic [ID_W-1:0]  pipe_tag;
   logic             pipe_busy;

   // Cyclic search from rr_ptr; reset gating keeps req_ready low while rst_n is asserted.
   always_comb begin : grant_comb
      int unsigned idx;
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      req_ready = '0;
      idx       = 0;
      if (rst_n && state == RUN) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req_valid[ID_W'(idx)] &&
                outstanding[ID_W'(idx)] < CNT_W'(MAX_OUT)) begin
               gnt_any = 1'b1;
               gnt_idx = ID_W'(idx);
            end
         end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   channel_add_pipe #(
      .WIDTH     (WIDTH),
      .ID_W      (ID_W),
      .LATENCY   (LATENCY),
      .ADD_CONST (ADD_CONST)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (gnt_any),
      .in_tag    (gnt_idx),
      .in_data   (req_data[gnt_idx*WIDTH +: WIDTH]),
      .out_valid (pipe_valid),
      .out_tag   (pipe_tag),
      .out_data  (resp_data),
      .busy      (pipe_busy)
   );

   always_comb begin
      resp_valid = '0;
      if (pipe_valid) resp_valid[pipe_tag] = 1'b1;
   end

   assign busy       = pipe_busy;
   assign flush_done = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = DRAIN;
         DRAIN:   if (!pipe_busy) state_nxt = flush ? DONE : RUN;
         DONE:    if (!flush) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
   end

   // Same-cycle issue and response to one requester cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREQ; i++) outstanding[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            case ({req_ready[i], resp_valid[i]})
               2'b10:   outstanding[i] <= outstanding[i] + CNT_W'(1);
               2'b01:   outstanding[i] <= outstanding[i] - CNT_W'(1);
               default: outstanding[i] <= outstanding[i];
            endcase
         end
      end
   end

`ifdef CHANNEL_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_count <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i] && grant_count[i*16 +: 16] != 16'hFFFF)
               grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule
